// File: rtl/mem_pkg.sv
// Shared types for the mem_pipe memory block.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_typ_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_st_e;

  // Width-independent part of a response; the data field is added by the
  // user, which knows DATA_BITS.
  typedef struct packed {
    mem_typ_e typ;
    logic     err;
  } rsp_hdr_t;

  localparam int RSP_HDR_BITS = $bits(rsp_hdr_t);

  // Total packed width of a response carrying data_bits of data.
  function automatic int rsp_bits(input int data_bits);
    return data_bits + RSP_HDR_BITS;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Two-entry FIFO; entry 0 is always the head.
// Latency: a push is visible at the head the cycle after the push edge when empty.
// Backpressure: owner must not push when count==2; push+pop together allowed at count 1 or 2.
// Ports: clk/rst (async active-high), push/push_data, pop, head_data, count.
module mem_rsp_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            ent0  <= push_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            ent0 <= push_data;
          end else if (push) begin
            ent1  <= push_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // Head leaves, second entry moves up; a simultaneous push refills slot 1.
          if (pop) begin
            ent0 <= ent1;
            if (push) begin
              ent1 <= push_data;
            end else begin
              count <= 2'd1;
            end
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign head_data = ent0;

endmodule

// File: rtl/mem_pipe.sv
// Single-port word memory with valid/ready request and response channels.
// Latency: response valid the cycle after acceptance; one request per cycle when consumer is ready.
// Backpressure: 2-entry response buffer; req_rdy_o drops while it is full and during the clear sweep.
// Ports: clk_i, rst_i (async active-high); req_{val,rdy,typ,addr,data,be}; rsp_{val,rdy,typ,data,err}.
module mem_pipe
  import mem_pkg::*;
#(
  parameter int DATA_BITS    = 32,
  parameter int DEPTH        = 128,
  parameter int WR_RSP       = 1,
  parameter int CLEAR_ON_RST = 1,
  localparam int ADDR_WIDTH  = $clog2(DEPTH),
  localparam int BE_WIDTH    = DATA_BITS / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_val_i,
  output logic                  req_rdy_o,
  input  logic                  req_typ_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_BITS-1:0]  req_data_i,
  input  logic [BE_WIDTH-1:0]   req_be_i,
  output logic                  rsp_val_o,
  input  logic                  rsp_rdy_i,
  output logic                  rsp_typ_o,
  output logic [DATA_BITS-1:0]  rsp_data_o,
  output logic                  rsp_err_o
);

  typedef struct packed {
    rsp_hdr_t                hdr;
    logic [DATA_BITS-1:0]    data;
  } rsp_t;

  localparam int RSP_W = rsp_bits(DATA_BITS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_BITS-1:0]  mem [DEPTH];

  mem_st_e               state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [1:0]            count;
  logic                  accept;
  logic                  is_wr;
  logic                  addr_err;
  logic                  wr_en;
  logic                  push;
  logic                  pop;
  rsp_t                  push_rsp;
  rsp_t                  head;

  assign is_wr    = (mem_typ_e'(req_typ_i) == MEM_WR);
  assign addr_err = ({1'b0, req_addr_i} >= DEPTH_W);
  assign accept   = req_val_i && req_rdy_o;
  assign wr_en    = accept && is_wr && !addr_err;
  // Out-of-range writes always answer so the error is never silently lost.
  assign push     = accept && (!is_wr || (WR_RSP != 0) || addr_err);
  assign pop      = rsp_val_o && rsp_rdy_i;

  always_comb begin
    push_rsp          = '0;
    push_rsp.hdr.typ  = mem_typ_e'(req_typ_i);
    push_rsp.hdr.err  = addr_err;
    if (!is_wr && !addr_err) begin
      push_rsp.data = mem[req_addr_i];
    end
  end

  // Sweep/control FSM; the array itself is deliberately left unreset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state    <= ST_RUN;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == ST_CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (req_be_i[b]) begin
          mem[req_addr_i][8*b +: 8] <= req_data_i[8*b +: 8];
        end
      end
    end
  end

  mem_rsp_fifo #(
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_rsp),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  // Ready depends only on registered state so it never loops through the consumer.
  assign req_rdy_o  = !rst_i && (state == ST_RUN) && (count != 2'd2);
  assign rsp_val_o  = (count != 2'd0);
  assign rsp_typ_o  = head.hdr.typ;
  assign rsp_err_o  = head.hdr.err;
  assign rsp_data_o = head.data;

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench: DEPTH=128 and DEPTH=100 instances share one request stream.
// Latency: checks sample #1 after each rising edge.
// Backpressure: rsp_rdy driven per test phase.
module tb_mem_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_val = 1'b0;
  logic        req_typ = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_rdy = 1'b1;

  logic        rdy_a, val_a, typ_a, err_a;
  logic [31:0] data_a;
  logic        rdy_b, val_b, typ_b, err_b;
  logic [31:0] data_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_pipe #(.DATA_BITS(32), .DEPTH(128), .WR_RSP(1), .CLEAR_ON_RST(1)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_val_i(req_val), .req_rdy_o(rdy_a), .req_typ_i(req_typ),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
    .rsp_val_o(val_a), .rsp_rdy_i(rsp_rdy), .rsp_typ_o(typ_a),
    .rsp_data_o(data_a), .rsp_err_o(err_a)
  );

  mem_pipe #(.DATA_BITS(32), .DEPTH(100), .WR_RSP(1), .CLEAR_ON_RST(1)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_val_i(req_val), .req_rdy_o(rdy_b), .req_typ_i(req_typ),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_be_i(req_be),
    .rsp_val_o(val_b), .rsp_rdy_i(rsp_rdy), .rsp_typ_o(typ_b),
    .rsp_data_o(data_b), .rsp_err_o(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request for a single edge; outputs are sampled #1 after it.
  task automatic issue(input logic typ, input logic [6:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    req_val  = 1'b1;
    req_typ  = typ;
    req_addr = addr;
    req_data = data;
    req_be   = be;
    @(posedge clk);
    #1;
    req_val  = 1'b0;
  endtask

  // Called right after reset release: ready must stay low through the sweep.
  task automatic sweep_check(input string pfx);
    logic early_a = 1'b0;
    logic early_b = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      @(posedge clk);
      #1;
      if (k < 128 && rdy_a) early_a = 1'b1;
      if (k < 100 && rdy_b) early_b = 1'b1;
      if (k == 100) chk({pfx, "_rdy_b_at_100"}, 64'(rdy_b), 64'd1);
      if (k == 127) chk({pfx, "_rdy_a_at_127"}, 64'(rdy_a), 64'd0);
      if (k == 128) chk({pfx, "_rdy_a_at_128"}, 64'(rdy_a), 64'd1);
    end
    chk({pfx, "_no_early_rdy_a"}, 64'(early_a), 64'd0);
    chk({pfx, "_no_early_rdy_b"}, 64'(early_b), 64'd0);
  endtask

  initial begin
    logic rdy_drop;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  64'(rdy_a),  64'd0);
    chk("rst_val",  64'(val_a),  64'd0);
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_err",  64'(err_a),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep_check("init");

    // Cleared top word
    issue(1'b0, 7'h7F, 32'h0, 4'h0);
    chk("rd7f_val",  64'(val_a),  64'd1);
    chk("rd7f_data", 64'(data_a), 64'd0);
    chk("rd7f_err",  64'(err_a),  64'd0);

    // Byte enables
    issue(1'b1, 7'd5, 32'hDEADBEEF, 4'b1111);
    chk("wr1_typ",  64'(typ_a),  64'd1);
    chk("wr1_data", 64'(data_a), 64'd0);
    issue(1'b1, 7'd5, 32'h000000AA, 4'b0001);
    chk("wr2_typ",  64'(typ_a),  64'd1);
    chk("wr2_data", 64'(data_a), 64'd0);
    issue(1'b0, 7'd5, 32'h0, 4'h0);
    chk("rd5_data", 64'(data_a), 64'hDEADBEAA);
    chk("rd5_typ",  64'(typ_a),  64'd0);
    chk("rd5_err",  64'(err_a),  64'd0);

    // Streaming at full rate
    for (int i = 0; i < 16; i++) issue(1'b1, 7'(i), 32'(i * 3), 4'hF);
    rdy_drop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 7'(i), 32'h0, 4'h0);
      if (!rdy_a || !val_a) rdy_drop = 1'b1;
      chk($sformatf("stream_%0d", i), 64'(data_a), 64'(i * 3));
    end
    chk("stream_rdy_held", 64'(rdy_drop), 64'd0);
    @(posedge clk);
    #1;
    chk("stream_drained", 64'(val_a), 64'd0);

    // Backpressure: third read held off until a pop
    rsp_rdy  = 1'b0;
    req_val  = 1'b1;
    req_typ  = 1'b0;
    req_addr = 7'd1;
    @(posedge clk); #1;
    req_addr = 7'd2;
    @(posedge clk); #1;
    chk("bp_full_rdy",  64'(rdy_a),  64'd0);
    chk("bp_head0",     64'(data_a), 64'd3);
    req_addr = 7'd3;
    @(posedge clk); #1;
    chk("bp_stall_val",  64'(val_a),  64'd1);
    chk("bp_stall_data", 64'(data_a), 64'd3);
    chk("bp_stall_rdy",  64'(rdy_a),  64'd0);
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_head1",     64'(data_a), 64'd6);
    chk("bp_rdy_back",  64'(rdy_a),  64'd1);
    @(posedge clk); #1;
    chk("bp_head2",     64'(data_a), 64'd9);
    req_val = 1'b0;
    @(posedge clk); #1;
    chk("bp_empty",     64'(val_a),  64'd0);

    // Out-of-range on the DEPTH=100 instance
    issue(1'b1, 7'd99, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 7'd100, 32'h12345678, 4'hF);
    chk("oor_wr_err_b", 64'(err_b),  64'd1);
    chk("oor_wr_typ_b", 64'(typ_b),  64'd1);
    chk("oor_wr_dat_b", 64'(data_b), 64'd0);
    chk("inr_wr_err_a", 64'(err_a),  64'd0);
    issue(1'b0, 7'd100, 32'h0, 4'h0);
    chk("oor_rd_dat_b", 64'(data_b), 64'd0);
    chk("oor_rd_err_b", 64'(err_b),  64'd1);
    chk("inr_rd_dat_a", 64'(data_a), 64'h12345678);
    issue(1'b0, 7'd99, 32'h0, 4'h0);
    chk("rd99_dat_b",   64'(data_b), 64'hCAFEF00D);
    chk("rd99_err_b",   64'(err_b),  64'd0);
    @(posedge clk); #1;

    // Reset with two responses pending
    rsp_rdy = 1'b0;
    issue(1'b0, 7'd99, 32'h0, 4'h0);
    issue(1'b0, 7'd100, 32'h0, 4'h0);
    chk("pend_val", 64'(val_a), 64'd1);
    chk("pend_rdy", 64'(rdy_a), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_val_a",  64'(val_a),  64'd0);
    chk("arst_val_b",  64'(val_b),  64'd0);
    chk("arst_data_b", 64'(data_b), 64'd0);
    chk("arst_rdy_a",  64'(rdy_a),  64'd0);
    @(negedge clk);
    rst     = 1'b0;
    rsp_rdy = 1'b1;

    // Reset mid-sweep
    repeat (40) @(posedge clk);
    #1;
    chk("mid_rdy", 64'(rdy_a), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(rdy_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep_check("resweep");

    issue(1'b0, 7'd5, 32'h0, 4'h0);
    chk("resweep_rd5", 64'(data_a), 64'd0);
    issue(1'b0, 7'd100, 32'h0, 4'h0);
    chk("resweep_rd100", 64'(data_a), 64'd0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_pipe.md
# mem_pipe

Parametrised single-port memory with valid/ready request and response channels, byte-enabled writes, out-of-range error signalling, a 2-entry response buffer for full-throughput backpressure, and a post-reset clear sweep. It sits between a requesting pipeline stage and the response consumer as the successor to the team's fixed-size scratch memory.

## Interface
- DATA_BITS, 32, data word width in bits; must be a multiple of 8
- DEPTH, 128, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), derived localparam
- BE_WIDTH, DATA_BITS/8, derived localparam
- WR_RSP, 1, 1 = writes produce a response, 0 = writes are silent
- CLEAR_ON_RST, 1, 1 = zero all words after reset, 0 = skip the sweep; contents undefined
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_val_i  in  1  request valid
- req_rdy_o  out  1  request ready
- req_typ_i  in  1  0 = read, 1 = write
- req_addr_i  in  ADDR_WIDTH  word address
- req_data_i  in  DATA_BITS  write data
- req_be_i  in  BE_WIDTH  write byte enables; ignored on reads
- rsp_val_o  out  1  response valid
- rsp_rdy_i  in  1  response ready
- rsp_typ_o  out  1  type of the request that produced this response
- rsp_data_o  out  DATA_BITS  read data; 0 for write responses
- rsp_err_o  out  1  address was >= DEPTH

## Operation
- FSM states: CLEAR and RUN. Reset enters CLEAR when CLEAR_ON_RST=1, otherwise RUN.
- CLEAR: one word per cycle is zeroed, addresses 0 to DEPTH-1. Transition to RUN on the cycle after address DEPTH-1 is written. req_rdy_o=0 throughout.
- RUN: req_rdy_o = (rsp buffer count < 2). It does not depend combinationally on rsp_rdy_i or req_val_i.
- Request accepted on an edge where req_val_i && req_rdy_o.
  - Read: array read at that edge; {typ=0, data, err=0} pushed into the response buffer.
  - Write: bytes with req_be_i[b]=1 are updated; other bytes are preserved. If WR_RSP=1, {typ=1, data=0, err=0} is pushed.
- Out-of-range (addr >= DEPTH):
  - A write does not modify the array.
  - A read returns data 0.
  - err=1 is set in the response. A write response with err=1 is pushed even when WR_RSP=0.
- Response buffer: 2-entry FIFO. Head drives rsp_*_o. Pop on rsp_val_o && rsp_rdy_i. Push and pop in the same edge are allowed when count is 1 or 2.
- Reset (any time, including mid-sweep or with responses pending):
  - Buffer emptied; sweep counter returns to 0.
  - Outputs: req_rdy_o=0, rsp_val_o=0, rsp_typ_o=0, rsp_data_o=0, rsp_err_o=0.
  - Pending responses are discarded.

## Timing
- Read latency: a request accepted at edge E gives rsp_val_o=1 from E until it is popped. This is one cycle in handshake terms.
- Read-after-write to the same address in consecutive accepts returns the new data.
- A consumer that is always ready sustains 1 request/cycle: count never exceeds 1 and req_rdy_o stays 1.
- When the consumer stalls, at most 2 responses are buffered. req_rdy_o drops the cycle after count reaches 2 and rises the cycle after a pop.
- Clear sweep takes DEPTH cycles after reset release. The first acceptance is possible at cycle DEPTH+1.
- rsp_*_o stay stable while rsp_val_o && !rsp_rdy_i.

## Structure
- Package mem_pkg:
  - enum mem_typ_e {MEM_RD=1'b0, MEM_WR=1'b1}
  - typedef enum for FSM states {ST_CLEAR, ST_RUN}
  - parameterised response struct helper (typ, err, data)
- Sub-module mem_rsp_fifo: 2-entry FIFO with push/pop, count output and data width parameter. Keep it separate and reusable.
- Array is a plain register/SRAM-inferable array with no reset. Only the control, the FIFO and the sweep counter are async-reset.

## Test plan
- Reset then idle, DEPTH=128, CLEAR_ON_RST=1: req_rdy_o=0 for 128 cycles, 1 at cycle 129. A read of addr 0x7F then returns 0x00000000.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x000000AA to addr 5 with be=4'b0001, then read addr 5: returns 0xDEADBEAA, rsp_typ_o=0, err=0. Each write gives a typ=1 response with data 0.
- Streaming, rsp_rdy_i=1: 16 back-to-back reads of addrs 0..15, previously written with addr*3. Responses arrive on consecutive cycles with values 0, 3, 6, … 45. req_rdy_o never drops.
- Backpressure: rsp_rdy_i=0 with 3 reads offered. Only 2 are accepted and req_rdy_o=0. Raising rsp_rdy_i drains the responses in order and the third read is accepted; no responses are lost or duplicated.
- DEPTH=100: write 0x12345678 to addr 100, then read addr 100. Write response has err=1. The read returns 0 with err=1. Addr 99 is unchanged.
- Assert rst_i mid-sweep at cycle 40 and again with 2 responses pending. rsp_val_o=0 immediately (asynchronous). The sweep restarts from 0, and req_rdy_o stays 0 for a full DEPTH cycles after release.
